fdd_mfm_tx: RTL and testbench

FDD_MFM_TX -- requirements
Module: fdd_mfm_tx

---
 rtl/fdd_mfm_tx.sv | 151 +++++++++++++++
 tb/tb_fdd_mfm_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdd_mfm_tx.sv
// fdd_mfm_tx: floppy-drive read-side emulator; MFM-encodes a byte stream onto rdat_n with index and track status.
// Head stepping is built only when FDD_MFM_TX_SEEK_EN is defined; otherwise the head is parked on track 0.
module fdd_mfm_tx #(
    parameter int unsigned HALFCELL = 56,
    parameter int unsigned PULSE_W  = 14,
    parameter int unsigned REV_HC   = 100000,
    parameter int unsigned IDX_HC   = 128,
    parameter int unsigned MAXTRK   = 79
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       motor_on,
    input  logic [7:0] byte_data,
    input  logic       byte_mark,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       step,
    input  logic       dir,
    output logic       rdat_n,
    output logic       index_n,
    output logic       tr00_n,
    output logic [6:0] track,
    output logic       underrun
);
    localparam int unsigned TW = (HALFCELL > 1) ? $clog2(HALFCELL) : 1;
    localparam int unsigned RW = (REV_HC > 1) ? $clog2(REV_HC) : 1;
    localparam logic [15:0] MARK_WORD = 16'h4489;
    localparam logic [7:0]  FILL_BYTE = 8'h4E;

    // MFM: clock half-cell set only between two zero data bits.
    function automatic logic [15:0] mfm_encode(input logic prev, input logic [7:0] data);
        logic [15:0] word;
        logic [7:0]  rest;
        logic        last;
        logic        cur;
        word = '0;
        rest = data;
        last = prev;
        for (int i = 0; i < 8; i++) begin
            cur  = rest[7];
            word = {word[13:0], ~cur & ~last, cur};
            last = cur;
            rest = {rest[6:0], 1'b0};
        end
        return word;
    endfunction

    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    hc_q, hc_d;
    logic [15:0]   shift_q, shift_d;
    logic          prev_q, prev_d;
    logic [RW-1:0] rot_q, rot_d;
    logic          under_d, rdat_d, index_d;
    logic          wrap, load;

    assign wrap = motor_on && (timer_q == TW'(HALFCELL - 1));
    assign load = wrap && (hc_q == 4'd15);
    // Acknowledge within the load cycle so the source can advance on the same edge.
    assign byte_ready = rst_n && load && byte_valid;

    always_comb begin
        timer_d = timer_q;
        hc_d    = hc_q;
        shift_d = shift_q;
        prev_d  = prev_q;
        rot_d   = rot_q;
        under_d = underrun;
        if (motor_on) begin
            timer_d = wrap ? '0 : timer_q + TW'(1);
        end
        if (load) begin
            hc_d = 4'd0;
            if (!byte_valid) begin
                shift_d = mfm_encode(prev_q, FILL_BYTE);
                prev_d  = FILL_BYTE[0];
                under_d = 1'b1;
            end else if (byte_mark) begin
                shift_d = MARK_WORD;
                prev_d  = 1'b1;
            end else begin
                shift_d = mfm_encode(prev_q, byte_data);
                prev_d  = byte_data[0];
            end
        end else if (wrap) begin
            hc_d    = hc_q + 4'd1;
            shift_d = {shift_q[14:0], 1'b0};
        end
        if (wrap) begin
            rot_d = (rot_q == RW'(REV_HC - 1)) ? '0 : rot_q + RW'(1);
        end
        // Pulse occupies the first PULSE_W counts of a 1 half-cell; idle high while stopped.
        rdat_d  = ~(motor_on && shift_d[15] && (32'(timer_d) < PULSE_W));
        index_d = ~(32'(rot_d) < IDX_HC);
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            timer_q  <= '0;
            hc_q     <= 4'd15;
            shift_q  <= '0;
            prev_q   <= 1'b0;
            rot_q    <= '0;
            underrun <= 1'b0;
            rdat_n   <= 1'b1;
            index_n  <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            hc_q     <= hc_d;
            shift_q  <= shift_d;
            prev_q   <= prev_d;
            rot_q    <= rot_d;
            underrun <= under_d;
            rdat_n   <= rdat_d;
            index_n  <= index_d;
        end
    end

`ifdef FDD_MFM_TX_SEEK_EN
    logic [2:0] step_sync;
    logic [6:0] track_d;

    // dir is expected stable around a step edge, so it is used directly.
    always_comb begin
        track_d = track;
        if (step_sync[1] && !step_sync[2]) begin
            if (dir) begin
                if (track < 7'(MAXTRK)) track_d = track + 7'd1;
            end else if (track != 7'd0) begin
                track_d = track - 7'd1;
            end
        end
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            step_sync <= '0;
            track     <= '0;
        end else begin
            step_sync <= {step_sync[1:0], step};
            track     <= track_d;
        end
    end

    assign tr00_n = (track != 7'd0);
`else
    logic unused_seek;
    assign unused_seek = step ^ dir ^ (MAXTRK == 0);
    assign track  = '0;
    assign tr00_n = 1'b0;
`endif
endmodule

// File: tb/tb_fdd_mfm_tx.sv
// tb_fdd_mfm_tx: stimulus predicts loaded words and byte_ready cycles into queues;
// a negedge monitor replays the expected half-cell stream against rdat_n, index_n and underrun.
module tb_fdd_mfm_tx;
    localparam int unsigned HC    = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned REV   = 200;
    localparam int unsigned IDX   = 10;
    localparam int unsigned MAXT  = 79;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic       fclk       = 1'b0;
    logic       rst_n      = 1'b0;
    logic       motor_on   = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       byte_mark  = 1'b0;
    logic       byte_valid = 1'b0;
    logic       step       = 1'b0;
    logic       dir        = 1'b0;
    logic       byte_ready, rdat_n, index_n, tr00_n, underrun;
    logic [6:0] track;

    fdd_mfm_tx #(
        .HALFCELL(HC), .PULSE_W(PW), .REV_HC(REV), .IDX_HC(IDX), .MAXTRK(MAXT)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .motor_on(motor_on), .byte_data(byte_data),
        .byte_mark(byte_mark), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .step(step), .dir(dir), .rdat_n(rdat_n), .index_n(index_n),
        .tr00_n(tr00_n), .track(track), .underrun(underrun)
    );

    always #5 fclk = ~fclk;

    int unsigned cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [15:0] word_q[$];
    int unsigned rdy_q[$];
    int unsigned under_from = NEVER;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endfunction

    // Reference MFM rule: each data bit emits (clock, data), clock = neither it nor the previous bit is 1.
    function automatic logic [15:0] mfm_word(input logic prev, input logic [7:0] b);
        logic [15:0] w;
        logic        p;
        logic        d;
        w = '0;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            d = b[3'(i)];
            w = (w << 2) | {14'd0, !(d || p), d};
            p = d;
        end
        return w;
    endfunction

    // Stimulus-side view: motor-on edges since reset and the data bit carried across words.
    logic       drv_mo = 1'b0, drv_v = 1'b0, drv_mk = 1'b0, drv_step = 1'b0, drv_dir = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       last_rst_s = 1'b0, last_mo_s = 1'b0;
    logic       mp = 1'b0;
    int unsigned m_s = 0;
    int          off_left = 0;
    int          model_track = 0;

    task automatic tick(input logic r, output bit slot);
        logic [7:0] fill;
        fill = 8'h4E;
        @(posedge fclk);
        #2;
        if (!last_rst_s) begin
            m_s = 0;
            mp = 1'b0;
            under_from = NEVER;
            word_q.delete();
            rdy_q.delete();
        end else if (last_mo_s) begin
            m_s++;
        end
        rst_n = r; motor_on = drv_mo; byte_valid = drv_v; byte_mark = drv_mk;
        byte_data = drv_data; step = drv_step; dir = drv_dir;
        slot = r && drv_mo && (m_s % HC == HC - 1) && ((m_s / HC) % 16 == 0);
        if (slot) begin
            if (drv_v) begin
                rdy_q.push_back(cyc);
                word_q.push_back(drv_mk ? 16'h4489 : mfm_word(mp, drv_data));
                mp = drv_mk ? 1'b1 : drv_data[0];
            end else begin
                word_q.push_back(mfm_word(mp, fill));
                mp = fill[0];
                if (under_from == NEVER) under_from = cyc + 1;
            end
        end
        last_rst_s = r;
        last_mo_s  = drv_mo;
    endtask

    task automatic rand_drive(input bit allow_inv);
        if (off_left > 0) begin
            drv_mo = 1'b0;
            off_left--;
        end else begin
            drv_mo = 1'b1;
            if ($urandom_range(0, 99) == 0) off_left = $urandom_range(1, 20);
        end
        if ($urandom_range(0, 3) == 0) begin
            drv_data = 8'($urandom);
            drv_mk   = ($urandom_range(0, 7) == 0);
        end
        drv_v = allow_inv ? ($urandom_range(0, 5) != 0) : 1'b1;
    endtask

    task automatic run_to_slot(input string name);
        bit s;
        int n;
        n = 0;
        do begin
            tick(1'b1, s);
            n++;
        end while (!s && n < 200);
        if (!s) chk({name, "_slot_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic step_pulse(input logic d);
        bit s;
        drv_dir = d;
        for (int i = 0; i < 6; i++) begin
            rand_drive(1'b0);
            drv_step = (i < 3);
            tick(1'b1, s);
        end
`ifdef FDD_MFM_TX_SEEK_EN
        if (d) model_track = (model_track < int'(MAXT)) ? model_track + 1 : model_track;
        else   model_track = (model_track > 0) ? model_track - 1 : 0;
`endif
        chk("track", 32'(track), 32'(model_track));
        chk("tr00_n", 32'(tr00_n), 32'(model_track != 0));
    endtask

    // Monitor: rebuilds the expected flux stream from the word queue, decoupled from stimulus.
    logic        mon_rst = 1'b0, mon_mo = 1'b0;
    int unsigned m_m = 0, popped_h = 0;
    logic [15:0] cur_word = '0;

    always @(negedge fclk) begin
        int unsigned t, h, j;
        logic exp_rdat, exp_rdy;
        if (!mon_rst) begin
            m_m = 0;
            popped_h = 0;
            cur_word = '0;
        end else if (mon_mo) begin
            m_m++;
        end
        t = m_m % HC;
        h = m_m / HC;
        exp_rdat = 1'b1;
        if (mon_rst && mon_mo && h >= 1) begin
            j = (h - 1) % 16;
            if (j == 0 && t == 0 && popped_h != h) begin
                popped_h = h;
                checks++;
                if (word_q.size() == 0) begin
                    errors++;
                    cur_word = '0;
                    $display("FAIL word_q: got empty queue expected a loaded word at half-cell %0d", h);
                end else begin
                    cur_word = word_q.pop_front();
                end
            end
            exp_rdat = !(cur_word[4'(15 - j)] && (t < PW));
        end
        chk("rdat_n", 32'(rdat_n), 32'(exp_rdat));
        chk("index_n", 32'(index_n), 32'(!((h % REV) < IDX)));
        chk("underrun", 32'(underrun), 32'(under_from != NEVER && cyc >= under_from));
        exp_rdy = (rdy_q.size() > 0) && (rdy_q[0] == cyc);
        if (exp_rdy) void'(rdy_q.pop_front());
        chk("byte_ready", 32'(byte_ready), 32'(exp_rdy));
        mon_rst = rst_n;
        mon_mo  = motor_on;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        bit seen;
        for (int i = 0; i < 3; i++) tick(1'b0, s);

        // Constant 8'h00 stream: clock-only pulses every other half-cell.
        drv_mo = 1'b1; drv_v = 1'b1; drv_data = 8'h00; drv_mk = 1'b0;
        for (int i = 0; i < 300; i++) tick(1'b1, s);

        // Address mark after a zero word, then 8'hFF.
        run_to_slot("zero");
        drv_mk = 1'b1;
        run_to_slot("mark");
        drv_mk = 1'b0; drv_data = 8'hFF;
        run_to_slot("ff");
        for (int i = 0; i < 150; i++) tick(1'b1, s);

        for (int i = 0; i < 2000; i++) begin
            rand_drive(1'b0);
            tick(1'b1, s);
        end

        // Long motor stop mid-revolution stretches the index period.
        drv_mo = 1'b0;
        for (int i = 0; i < 100; i++) tick(1'b1, s);
        drv_mo = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 3) == 0) drv_data = 8'($urandom);
            tick(1'b1, s);
        end

        off_left = 0;
        for (int i = 0; i < 85; i++) step_pulse(1'b1);
        for (int i = 0; i < 80; i++) step_pulse(1'b0);
        for (int i = 0; i < 10; i++) step_pulse(1'($urandom_range(0, 1)));
        drv_step = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            rand_drive(1'b1);
            tick(1'b1, s);
        end

        // Reset while rdat_n is low.
        off_left = 0; drv_mo = 1'b1; drv_v = 1'b1; drv_data = 8'h00; drv_mk = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(1'b1, s);
            if (rdat_n === 1'b0) seen = 1'b1;
        end
        chk("pulse_seen_before_reset", 32'(seen), 32'd1);
        tick(1'b0, s);
        tick(1'b1, s);
        model_track = 0;
        chk("rst_rdat_n", 32'(rdat_n), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_track", 32'(track), 32'd0);
        chk("rst_tr00_n", 32'(tr00_n), 32'd0);
        chk("rst_index_n", 32'(index_n), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);

        for (int i = 0; i < 3; i++) step_pulse(1'b1);
        drv_step = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rand_drive(1'b0);
            tick(1'b1, s);
        end

        @(negedge fclk);
        #1;
        chk("byte_ready_pending", 32'(rdy_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
